lcd12864_bus_sched: RTL and testbench

Shared write scheduler for the LCD12864 parallel bus (ST7920-class controller, 8-bit mode, write-only). After reset it runs the panel power-up and initialisation sequence itself. It then arbitrates byte writes from two independent requesters, for example a text/frame writer and a status/cursor writer, and times RS, DAT and E to the controller's setup, pulse-width and execution-time limits. It sits between the display content logic and the panel pins, replacing free-running divided-clock E generation.

---
 rtl/lcd12864_bus_sched.sv | 157 +++++++++++++++
 tb/tb_lcd12864_bus_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd12864_bus_sched.sv
// Write-only scheduler for an ST7920-class LCD12864 8-bit parallel bus: runs the
// power-up/init sequence, then round-robin arbitrates two byte requesters and times RS/DAT/E.
module lcd12864_bus_sched #(
    parameter int T_SU  = 4,
    parameter int T_EH  = 16,
    parameter int T_CYC = 3600,
    parameter int T_CLR = 80000,
    parameter int T_PWR = 2000000,
    parameter int CW    = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_dat,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_dat,
    output logic       req1_ready,
    output logic       init_done,
    output logic       busy,
    output logic       rs,
    output logic       rw,
    output logic       en,
    output logic [7:0] dat
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_LOAD,
        SETUP,
        EHIGH,
        WAIT,
        IDLE
    } state_t;

    localparam logic [CW-1:0] PWR_LAST = CW'(T_PWR - 1);
    localparam logic [CW-1:0] SU_LAST  = CW'(T_SU - 1);
    localparam logic [CW-1:0] EH_LAST  = CW'(T_EH - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(T_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(T_CLR - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wait_last;
    logic [1:0]    idx;
    logic          ptr;
    logic          cnt_clr;
    logic          grant0;
    logic          grant1;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h30;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= PWR_WAIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cnt_clr   = 1'b0;
        grant0    = 1'b0;
        grant1    = 1'b0;
        // clear and home need the long execution time
        wait_last = (!rs && (dat == 8'h01 || dat == 8'h02)) ? CLR_LAST : CYC_LAST;
        case (state)
            PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    state_nx = INIT_LOAD;
                    cnt_clr  = 1'b1;
                end
            end
            INIT_LOAD: begin
                state_nx = SETUP;
                cnt_clr  = 1'b1;
            end
            SETUP: begin
                if (cnt == SU_LAST) begin
                    state_nx = EHIGH;
                    cnt_clr  = 1'b1;
                end
            end
            EHIGH: begin
                if (cnt == EH_LAST) begin
                    state_nx = WAIT;
                    cnt_clr  = 1'b1;
                end
            end
            WAIT: begin
                if (cnt == wait_last) begin
                    cnt_clr  = 1'b1;
                    state_nx = (init_done || idx == 2'd3) ? IDLE : INIT_LOAD;
                end
            end
            IDLE: begin
                cnt_clr = 1'b1;
                if (init_done) begin
                    // ptr=0 favours requester 0 when both are valid
                    grant0 = req0_valid && (!req1_valid || !ptr);
                    grant1 = req1_valid && !grant0;
                    if (grant0 || grant1) state_nx = SETUP;
                end
            end
            default: begin
                state_nx = PWR_WAIT;
                cnt_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= 2'd0;
            ptr       <= 1'b0;
            init_done <= 1'b0;
            rs        <= 1'b0;
            dat       <= 8'h00;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (state == INIT_LOAD) begin
                rs  <= 1'b0;
                dat <= init_byte(idx);
            end
            if (grant0) begin
                rs  <= req0_rs;
                dat <= req0_dat;
                ptr <= 1'b1;
            end
            if (grant1) begin
                rs  <= req1_rs;
                dat <= req1_dat;
                ptr <= 1'b0;
            end
            if (state == WAIT && cnt == wait_last && !init_done) begin
                if (idx == 2'd3) init_done <= 1'b1;
                else             idx       <= idx + 2'd1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);
    assign en         = (state == EHIGH);
    assign rw         = 1'b0;

endmodule

// File: tb/tb_lcd12864_bus_sched.sv
// Bench for lcd12864_bus_sched: a cycle-timeline model of the bus schedule checked every
// cycle, plus literal timing expectations for init, round-robin, clear wait and reset.
module tb_lcd12864_bus_sched;

    localparam int T_SU  = 2;
    localparam int T_EH  = 3;
    localparam int T_CYC = 5;
    localparam int T_CLR = 20;
    localparam int T_PWR = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req0_rs = 1'b0;
    logic [7:0] req0_dat = 8'h00;
    logic       req1_valid = 1'b0, req1_rs = 1'b0;
    logic [7:0] req1_dat = 8'h00;
    logic       req0_ready, req1_ready, init_done, busy, rs, rw, en;
    logic [7:0] dat;

    always #5 clk = ~clk;

    lcd12864_bus_sched #(
        .T_SU(T_SU), .T_EH(T_EH), .T_CYC(T_CYC), .T_CLR(T_CLR), .T_PWR(T_PWR), .CW(21)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_dat(req0_dat), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_dat(req1_dat), .req1_ready(req1_ready),
        .init_done(init_done), .busy(busy), .rs(rs), .rw(rw), .en(en), .dat(dat)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Timeline model: cycle t counts from the first cycle with rst low.
    int   t, load_t, free_t, init_end_t, en_lo, en_hi, init_n, idone_t;
    logic cur_rs;
    logic [7:0] cur_dat;
    logic fav;
    logic e0, e1;
    bit   rst_prev = 1'b1;
    bit   en_prev, idone_prev;
    bit   acc0, acc1;
    int   acc_t[$];
    int   acc_who[$];
    int   rise_t[$];
    int   rise_dat[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (model cycle %0d, time %0t)", name, act, exp, t, $time);
    endtask

    function automatic logic [7:0] rom(input int i);
        case (i)
            0:       return 8'h30;
            1:       return 8'h0C;
            2:       return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    task automatic model_reset();
        t = 0; load_t = T_PWR; free_t = 0; init_end_t = 0; init_n = 0;
        en_lo = 1; en_hi = 0; cur_rs = 1'b0; cur_dat = 8'h00; fav = 1'b0;
        en_prev = 1'b0; idone_prev = 1'b0; idone_t = -1;
        acc_t.delete(); acc_who.delete(); rise_t.delete(); rise_dat.delete();
    endtask

    task automatic start_write();
        en_lo  = t + 1 + T_SU;
        en_hi  = en_lo + T_EH - 1;
        free_t = en_hi + 1 + ((!cur_rs && (cur_dat == 8'h01 || cur_dat == 8'h02)) ? T_CLR : T_CYC);
    endtask

    task automatic check_model();
        bit idle;
        idle = (init_n == 4) && (t >= free_t);
        e0 = 1'b0;
        e1 = 1'b0;
        if (idle) begin
            if (req0_valid && req1_valid) begin
                if (fav) e1 = 1'b1;
                else     e0 = 1'b1;
            end else begin
                e0 = req0_valid;
                e1 = req1_valid;
            end
        end
        chk("rs", int'(rs), int'(cur_rs));
        chk("dat", int'(dat), int'(cur_dat));
        chk("en", int'(en), int'(t >= en_lo && t <= en_hi));
        chk("rw", int'(rw), 0);
        chk("busy", int'(busy), int'(!idle));
        chk("init_done", int'(init_done), int'(init_n == 4 && t >= init_end_t));
        chk("req0_ready", int'(req0_ready), int'(e0));
        chk("req1_ready", int'(req1_ready), int'(e1));
    endtask

    task automatic model_update();
        if (init_n < 4 && t == load_t) begin
            cur_rs  = 1'b0;
            cur_dat = rom(init_n);
            start_write();
            init_n++;
            load_t     = free_t;
            init_end_t = free_t;
        end else if (e0 || e1) begin
            cur_rs  = e0 ? req0_rs : req1_rs;
            cur_dat = e0 ? req0_dat : req1_dat;
            start_write();
            fav = e0;
            acc_t.push_back(t);
            acc_who.push_back(e0 ? 0 : 1);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (rst_prev) begin
                chk("rst_rs", int'(rs), 0);
                chk("rst_dat", int'(dat), 0);
                chk("rst_en", int'(en), 0);
                chk("rst_busy", int'(busy), 1);
                chk("rst_init_done", int'(init_done), 0);
                chk("rst_ready", int'(req0_ready | req1_ready), 0);
            end else begin
                check_model();
            end
            rst_prev = 1'b1;
        end else begin
            if (rst_prev) model_reset();
            check_model();
            if (en && !en_prev) begin
                rise_t.push_back(t);
                rise_dat.push_back(int'(dat));
            end
            en_prev = en;
            if (init_done && !idone_prev && idone_t < 0) idone_t = t;
            idone_prev = init_done;
            model_update();
            t++;
            rst_prev = 1'b0;
        end
        acc0 = req0_ready;
        acc1 = req1_ready;
    end

    // 0: hold, 1: both streaming, 2: random, 3: drop valid once accepted
    int mode = 0;

    function automatic logic [7:0] pick_byte();
        if ($urandom_range(3) == 0) return ($urandom_range(1) == 0) ? 8'h01 : 8'h02;
        return 8'($urandom);
    endfunction

    task automatic update_reqs();
        case (mode)
            1: begin
                if (acc0) req0_dat = req0_dat + 8'd1;
                if (acc1) req1_dat = req1_dat + 8'd1;
            end
            2: begin
                if (acc0 || (req0_valid && $urandom_range(15) == 0)) req0_valid = 1'b0;
                if (!req0_valid && $urandom_range(2) == 0) begin
                    req0_valid = 1'b1; req0_rs = 1'($urandom_range(1)); req0_dat = pick_byte();
                end
                if (acc1 || (req1_valid && $urandom_range(15) == 0)) req1_valid = 1'b0;
                if (!req1_valid && $urandom_range(2) == 0) begin
                    req1_valid = 1'b1; req1_rs = 1'($urandom_range(1)); req1_dat = pick_byte();
                end
            end
            3: begin
                if (acc0) req0_valid = 1'b0;
                if (acc1) req1_valid = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        update_reqs();
    endtask

    task automatic check_init_literals(input string tag);
        int exp_rise[4];
        int exp_dat[4];
        exp_rise = '{13, 24, 35, 61};
        exp_dat  = '{8'h30, 8'h0C, 8'h01, 8'h06};
        chk({tag, "_rise_count"}, int'(rise_t.size() >= 4), 1);
        if (rise_t.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk({tag, "_rise_cycle"}, rise_t[i], exp_rise[i]);
                chk({tag, "_rise_dat"}, rise_dat[i], exp_dat[i]);
            end
        end
        chk({tag, "_init_done_cycle"}, idone_t, 69);
    endtask

    initial begin
        int n, sz;
        // Power-up with an early request already pending
        mode = 3;
        rst = 1'b1;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_dat = 8'h41;
        repeat (3) step();
        rst = 1'b0;
        n = 0;
        while (acc_t.size() < 1 && n < 300) begin step(); n++; end
        chk("first_accept_seen", int'(acc_t.size() >= 1), 1);
        if (acc_t.size() >= 1) begin
            chk("first_accept_cycle", acc_t[0], 69);
            chk("first_accept_who", acc_who[0], 0);
        end
        check_init_literals("init");

        // Both requesters streaming: grants alternate every 11 cycles
        mode = 1;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_dat = 8'h51;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_dat = 8'h61;
        sz = acc_t.size();
        n = 0;
        while (acc_t.size() < sz + 5 && n < 300) begin step(); n++; end
        chk("rr_accepts_seen", int'(acc_t.size() >= sz + 5), 1);
        if (acc_t.size() >= sz + 5) begin
            chk("rr_first_cycle", acc_t[sz], 80);
            chk("rr_first_who", acc_who[sz], 1);
            for (int i = 0; i < 4; i++) begin
                chk("rr_spacing", acc_t[sz+i+1] - acc_t[sz+i], 11);
                chk("rr_alternate", acc_who[sz+i+1], 1 - acc_who[sz+i]);
            end
        end

        // Clear command from requester 1 then a waiting requester 0
        mode = 3;
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin step(); n++; end
        chk("idle_reached", int'(busy), 0);
        req1_valid = 1'b1; req1_rs = 1'b0; req1_dat = 8'h01;
        sz = acc_t.size();
        n = 0;
        while (acc_t.size() == sz && n < 100) begin step(); n++; end
        req0_valid = 1'b1; req0_rs = 1'b1; req0_dat = 8'h77;
        n = 0;
        while (acc_t.size() < sz + 2 && n < 100) begin step(); n++; end
        chk("clr_accepts_seen", int'(acc_t.size() >= sz + 2), 1);
        if (acc_t.size() >= sz + 2) begin
            chk("clr_first_who", acc_who[sz], 1);
            chk("clr_second_who", acc_who[sz+1], 0);
            chk("clr_spacing", acc_t[sz+1] - acc_t[sz], 26);
        end

        // Random traffic against the model
        mode = 2;
        repeat (2000) step();

        // Reset in the middle of an E pulse
        mode = 3;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_dat = 8'h33;
        n = 0;
        while (en !== 1'b1 && n < 200) begin step(); n++; end
        chk("ehigh_reached", int'(en), 1);
        req0_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("ehigh_rst_en", int'(en), 0);
        chk("ehigh_rst_dat", int'(dat), 0);
        chk("ehigh_rst_init_done", int'(init_done), 0);
        chk("ehigh_rst_busy", int'(busy), 1);
        step();
        rst = 1'b0;
        repeat (80) step();
        check_init_literals("replay");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
